// File: rtl/mc_sequencer.sv
// Program sequencer: PC, JMP/RTN return stack, post-RTN skip, and address region decode (option: MC_SEQ_CIRCULAR_STACK_EN).
// Latency: pc/skip/depth/stack_err registered, one cycle after the sampling edge; region decode is combinational.
// Backpressure: advance=0 freezes all state; decode keeps following address_in.
module mc_sequencer #(
  parameter int ADDR_WIDTH  = 12,
  parameter int STACK_DEPTH = 4,
  parameter int INPUT_SIZE  = 5,
  parameter int OUTPUT_SIZE = 5,
  localparam int DW = $clog2(STACK_DEPTH + 1),
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  jmp,
  input  logic                  rtn,
  input  logic [ADDR_WIDTH-1:0] address_in,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  skip,
  output logic [DW-1:0]         depth,
  output logic                  stack_err,
  output logic                  rr_sel,
  output logic                  io_sel,
  output logic                  ram_sel
);

  localparam logic [ADDR_WIDTH-1:0] IO_LIMIT = ADDR_WIDTH'(INPUT_SIZE + OUTPUT_SIZE);
  localparam logic [DW-1:0]         FULL     = DW'(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic                  skip_nxt;
  logic [DW-1:0]         depth_nxt;
  logic                  err_nxt;
  logic                  push_en;
  logic [IW-1:0]         push_idx;
  logic [IW-1:0]         pop_idx;
`ifdef MC_SEQ_CIRCULAR_STACK_EN
  logic                  push_shift;
`endif

  always_comb begin
    rr_sel  = 1'b0;
    io_sel  = 1'b0;
    ram_sel = 1'b0;
    if (address_in == '1)
      rr_sel = 1'b1;
    else if (address_in < IO_LIMIT)
      io_sel = 1'b1;
    else
      ram_sel = 1'b1;
  end

  assign pc_inc   = pc + 1'b1;
  assign push_idx = depth[IW-1:0];
  assign pop_idx  = IW'(depth - 1'b1);

  // Priority: pending skip, then jmp, then rtn, then sequential fetch.
  always_comb begin
    pc_nxt    = pc;
    skip_nxt  = skip;
    depth_nxt = depth;
    err_nxt   = stack_err;
    push_en   = 1'b0;
`ifdef MC_SEQ_CIRCULAR_STACK_EN
    push_shift = 1'b0;
`endif
    if (advance) begin
      if (skip) begin
        pc_nxt   = pc_inc;
        skip_nxt = 1'b0;
      end else if (jmp) begin
        pc_nxt = address_in;
        if (depth != FULL) begin
          push_en   = 1'b1;
          depth_nxt = depth + 1'b1;
        end else begin
`ifdef MC_SEQ_CIRCULAR_STACK_EN
          push_shift = 1'b1;
`else
          err_nxt = 1'b1;
`endif
        end
      end else if (rtn) begin
        skip_nxt = 1'b1;
        if (depth != '0) begin
          pc_nxt    = stack_mem[pop_idx];
          depth_nxt = depth - 1'b1;
        end else begin
          pc_nxt  = pc_inc;
          err_nxt = 1'b1;
        end
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      skip      <= 1'b0;
      depth     <= '0;
      stack_err <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      skip      <= skip_nxt;
      depth     <= depth_nxt;
      stack_err <= err_nxt;
    end
  end

  // Stack contents need no reset: depth alone says what is valid.
  always_ff @(posedge clk) begin
    if (push_en)
      stack_mem[push_idx] <= pc_inc;
`ifdef MC_SEQ_CIRCULAR_STACK_EN
    if (push_shift) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++)
        stack_mem[i] <= stack_mem[i+1];
      stack_mem[STACK_DEPTH-1] <= pc_inc;
    end
`endif
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized and directed bench for mc_sequencer against a queue-based reference model.
module tb_mc_sequencer;
  localparam int AW = 12;
  localparam int SD = 4;
`ifdef MC_SEQ_CIRCULAR_STACK_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          advance = 1'b0;
  logic          jmp = 1'b0;
  logic          rtn = 1'b0;
  logic [AW-1:0] address_in = '0;
  logic [AW-1:0] pc;
  logic          skip;
  logic [2:0]    depth;
  logic          stack_err;
  logic          rr_sel, io_sel, ram_sel;

  mc_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .INPUT_SIZE(5), .OUTPUT_SIZE(5)) dut (
    .clk(clk), .reset(reset), .advance(advance), .jmp(jmp), .rtn(rtn),
    .address_in(address_in), .pc(pc), .skip(skip), .depth(depth),
    .stack_err(stack_err), .rr_sel(rr_sel), .io_sel(io_sel), .ram_sel(ram_sel)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit          chk_en = 1'b0;

  // Reference model
  int unsigned m_pc;
  bit          m_skip;
  bit          m_err;
  int unsigned m_stk[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_skip = 0; m_err = 0; m_stk.delete();
  endtask

  task automatic model_step(input bit a, input bit j, input bit r, input int unsigned tgt);
    int unsigned ret;
    if (!a) return;
    ret = (m_pc + 1) % 4096;
    if (m_skip) begin
      m_pc = ret; m_skip = 0;
    end else if (j) begin
      if (m_stk.size() < SD) m_stk.push_back(ret);
      else if (CIRC) begin void'(m_stk.pop_front()); m_stk.push_back(ret); end
      else m_err = 1;
      m_pc = tgt;
    end else if (r) begin
      m_skip = 1;
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_pc = ret; m_err = 1; end
    end else begin
      m_pc = ret;
    end
  endtask

  // Compare process: every negedge, outputs against model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", 32'(pc), m_pc);
      chk("skip", 32'(skip), 32'(m_skip));
      chk("depth", 32'(depth), m_stk.size());
      chk("stack_err", 32'(stack_err), 32'(m_err));
      chk("rr_sel", 32'(rr_sel), 32'(address_in == 12'hFFF));
      chk("io_sel", 32'(io_sel), 32'(address_in != 12'hFFF && address_in < 12'd10));
      chk("ram_sel", 32'(ram_sel), 32'(address_in != 12'hFFF && address_in >= 12'd10));
    end
  end

  task automatic step(input bit a, input bit j, input bit r, input logic [AW-1:0] tgt);
    advance = a; jmp = j; rtn = r; address_in = tgt;
    @(posedge clk);
    model_step(a, j, r, 32'(tgt));
    #2;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_pc", 32'(pc), 0);
    chk("reset_depth", 32'(depth), 0);
    chk("reset_skip", 32'(skip), 0);
    chk("reset_err", 32'(stack_err), 0);
    @(posedge clk); #2;
    reset = 1'b1;
    chk_en = 1'b1;

    // Plain counting through wraparound
    for (int i = 0; i < 4100; i++) step(1, 0, 0, 12'd20);
    chk("wrap_pc", 32'(pc), 4100 % 4096);

    // Call/return at pc=10
    apply_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 12'd20);
    chk("pre_jmp_pc", 32'(pc), 10);
    step(1, 1, 0, 12'h200);
    chk("jmp_pc", 32'(pc), 32'h200);
    chk("jmp_depth", 32'(depth), 1);
    step(1, 0, 0, 12'h050);
    step(1, 0, 1, 12'h050);
    chk("rtn_pc", 32'(pc), 11);
    chk("rtn_skip", 32'(skip), 1);
    step(1, 1, 0, 12'h300);
    chk("skip_ignores_jmp_pc", 32'(pc), 12);
    chk("skip_clear", 32'(skip), 0);
    chk("rtn_depth", 32'(depth), 0);

    // Underflow at pc=7
    apply_reset();
    for (int i = 0; i < 7; i++) step(1, 0, 0, 12'd20);
    step(1, 0, 1, 12'd20);
    chk("uf_pc", 32'(pc), 8);
    chk("uf_skip", 32'(skip), 1);
    chk("uf_err", 32'(stack_err), 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 12'd20);
    chk("uf_err_sticky", 32'(stack_err), 1);

    // Five nested calls on a four-deep stack
    apply_reset();
    step(1, 1, 0, 12'h100);
    step(1, 1, 0, 12'h200);
    step(1, 1, 0, 12'h300);
    step(1, 1, 0, 12'h400);
    step(1, 1, 0, 12'h500);
    chk("nest_depth", 32'(depth), 4);
    chk("nest_err", 32'(stack_err), CIRC ? 0 : 1);
    step(1, 0, 1, 12'd20);
    chk("nest_rtn1", 32'(pc), CIRC ? 32'h401 : 32'h301);
    step(1, 0, 0, 12'd20);
    for (int i = 0; i < 3; i++) begin step(1, 0, 1, 12'd20); step(1, 0, 0, 12'd20); end
    chk("nest_last_pc", 32'(pc), CIRC ? 32'h102 : 32'h2);

    // Stall with jmp held
    apply_reset();
    step(1, 0, 0, 12'd20);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 12'h0AB);
    chk("stall_pc", 32'(pc), 1);
    chk("stall_depth", 32'(depth), 0);
    step(1, 1, 0, 12'h0AB);
    chk("stall_jmp_pc", 32'(pc), 32'h0AB);

    // Decode literals
    address_in = 12'hFFF; #1;
    chk("dec_fff_rr", 32'({rr_sel, io_sel, ram_sel}), 32'b100);
    address_in = 12'h009; #1;
    chk("dec_009_io", 32'({rr_sel, io_sel, ram_sel}), 32'b010);
    address_in = 12'h00A; #1;
    chk("dec_00a_ram", 32'({rr_sel, io_sel, ram_sel}), 32'b001);

    // Randomized traffic
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a;
      case ($urandom_range(0, 3))
        0: a = 12'hFFF;
        1: a = 12'($urandom_range(0, 11));
        default: a = 12'($urandom);
      endcase
      step($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, a);
    end

    // Async reset mid-subroutine
    apply_reset();
    step(1, 1, 0, 12'h100);
    step(1, 1, 0, 12'h200);
    chk("pre_rst_depth", 32'(depth), 2);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_pc", 32'(pc), 0);
    chk("async_rst_depth", 32'(depth), 0);
    @(posedge clk); #2;
    reset = 1'b1;
    step(1, 0, 0, 12'd20);
    chk("post_rst_pc", 32'(pc), 1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
